piece_bag_scheduler: RTL and testbench

Piece sequencer for the Tetris game logic. It consumes the 3-bit pseudo-random stream from the LFSR source and enforces 7-bag fairness: every group of 7 consecutive pieces contains each of the 7 pieces exactly once. Accepted pieces go into a small preview FIFO. The game FSM pops the current piece and can read the next one for the preview display.

---
 rtl/piece_bag_scheduler.sv | 118 +++++++++++
 tb/tb_piece_bag_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_bag_scheduler.sv
// 7-bag Tetris piece sequencer: filters a 3-bit random stream so each bag of 7 holds every piece once,
// buffering accepted pieces in a small preview FIFO.
module piece_bag_scheduler #(
  parameter int DEPTH     = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] rnd,
  input  logic       restart,
  input  logic       piece_pop,
  output logic       piece_valid,
  output logic [2:0] piece_id,
  output logic       preview_valid,
  output logic [2:0] preview_id,
  output logic [6:0] bag_mask,
  output logic [3:0] count
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [1:0] {S_INIT, S_FILL, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [3:0]      count_q, count_d;
  logic [3:0]      tries_q, tries_d;
  logic [6:0]      mask_q, mask_d;
  logic [2:0]      mem_q [DEPTH];

  logic            draw, hit, fallback, push, pop;
  logic [2:0]      fb_id, push_id;
  logic [6:0]      mask_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Lowest-index piece not yet issued from the current bag.
  always_comb begin
    fb_id = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!mask_q[i]) fb_id = 3'(i);
    end
  end

  assign draw     = (state_q == S_FILL) && (count_q < DEPTH_C);
  assign hit      = draw && (rnd != 3'd7) && !mask_q[rnd];
  assign fallback = draw && !hit && (tries_q == LAST_TRY);
  assign push     = (hit || fallback) && !restart;
  assign pop      = piece_pop && (count_q != 4'd0) && !restart;
  assign push_id  = hit ? rnd : fb_id;
  assign mask_set = mask_q | (7'd1 << push_id);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    tries_d = tries_q;
    mask_d  = mask_q;
    if (restart) begin
      state_d = S_FILL;
      head_d  = '0;
      tail_d  = '0;
      count_d = 4'd0;
      tries_d = 4'd0;
      mask_d  = 7'd0;
    end else begin
      if (push) begin
        tail_d  = ptr_inc(tail_q);
        tries_d = 4'd0;
        // Completing a bag rolls straight into a fresh one.
        mask_d  = (mask_set == 7'h7F) ? 7'd0 : mask_set;
      end else if (draw) begin
        tries_d = tries_q + 4'd1;
      end
      if (pop) head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
      if (state_q == S_INIT) state_d = S_FILL;
      else                   state_d = (count_d == DEPTH_C) ? S_HOLD : S_FILL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 4'd0;
      tries_q <= 4'd0;
      mask_q  <= 7'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      tries_q <= tries_d;
      mask_q  <= mask_d;
      if (push) mem_q[tail_q] <= push_id;
    end
  end

  assign piece_valid   = (count_q != 4'd0);
  assign piece_id      = mem_q[head_q];
  assign preview_valid = (count_q >= 4'd2);
  assign preview_id    = mem_q[ptr_inc(head_q)];
  assign bag_mask      = mask_q;
  assign count         = count_q;

endmodule

// File: tb/tb_piece_bag_scheduler.sv
// Bench for piece_bag_scheduler: queue/bag model checked every cycle plus directed literal expectations.
module tb_piece_bag_scheduler;
  localparam int DEPTH     = 4;
  localparam int MAX_TRIES = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] rnd;
  logic       restart;
  logic       piece_pop;
  logic       piece_valid;
  logic [2:0] piece_id;
  logic       preview_valid;
  logic [2:0] preview_id;
  logic [6:0] bag_mask;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  piece_bag_scheduler #(.DEPTH(DEPTH), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .reset_n(reset_n), .rnd(rnd), .restart(restart), .piece_pop(piece_pop),
    .piece_valid(piece_valid), .piece_id(piece_id), .preview_valid(preview_valid),
    .preview_id(preview_id), .bag_mask(bag_mask), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue of pieces, the bag a set of issued pieces.
  int mq[$];
  bit bag[7];
  int tries;
  bit started;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      foreach (bag[i]) bag[i] = 1'b0;
      tries   = 0;
      started = 1'b0;
    end else if (restart) begin
      mq.delete();
      foreach (bag[i]) bag[i] = 1'b0;
      tries   = 0;
      started = 1'b1;
    end else begin
      int n, r, got, issued;
      bit do_draw;
      n       = mq.size();
      r       = int'(rnd);
      do_draw = started && (n < DEPTH);
      if (piece_pop && n > 0) void'(mq.pop_front());
      if (do_draw) begin
        got = -1;
        if (r <= 6 && !bag[r]) got = r;
        else if (tries == MAX_TRIES - 1) begin
          got = 0;
          while (bag[got]) got++;
        end else tries++;
        if (got >= 0) begin
          mq.push_back(got);
          bag[got] = 1'b1;
          tries    = 0;
          issued   = 0;
          foreach (bag[i]) issued += int'(bag[i]);
          if (issued == 7) foreach (bag[i]) bag[i] = 1'b0;
        end
      end
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      int m;
      m = 0;
      foreach (bag[i]) if (bag[i]) m += (1 << i);
      chk("m_count", int'(count), mq.size());
      chk("m_valid", int'(piece_valid), int'(mq.size() > 0));
      chk("m_preview_valid", int'(preview_valid), int'(mq.size() > 1));
      chk("m_bag_mask", int'(bag_mask), m);
      if (mq.size() > 0) chk("m_piece_id", int'(piece_id), mq[0]);
      if (mq.size() > 1) chk("m_preview_id", int'(preview_id), mq[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  int popped[$];
  logic [15:0] lfsr;

  initial begin
    reset_n = 1'b1; rnd = 3'd0; restart = 1'b0; piece_pop = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(piece_valid), 0);
    chk("rst_piece_id", int'(piece_id), 0);
    chk("rst_preview_valid", int'(preview_valid), 0);
    chk("rst_preview_id", int'(preview_id), 0);
    chk("rst_mask", int'(bag_mask), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    cyc();
    chk("init_edge_count", int'(count), 0);
    for (int i = 0; i < 4; i++) begin
      rnd = 3'(i);
      cyc();
      chk("fill_count", int'(count), i + 1);
    end
    chk("fill_piece_id", int'(piece_id), 0);
    chk("fill_preview_id", int'(preview_id), 1);
    chk("fill_mask", int'(bag_mask), 'h0F);

    // Pop on full with a rejected candidate, then 8-cycle fallback to piece 4.
    rnd = 3'd3; piece_pop = 1'b1;
    cyc();
    piece_pop = 1'b0;
    chk("pop_full_count", int'(count), 3);
    repeat (7) cyc();
    chk("fb_wait_count", int'(count), 3);
    cyc();
    chk("fb_done_count", int'(count), 4);
    chk("fb_mask", int'(bag_mask), 'h1F);
    chk("fb_piece_id", int'(piece_id), 1);

    // Pop on full with an acceptable candidate: no push that edge, push on the next.
    rnd = 3'd5; piece_pop = 1'b1;
    cyc();
    piece_pop = 1'b0;
    chk("pop_hit_count", int'(count), 3);
    cyc();
    chk("refill_count", int'(count), 4);
    chk("refill_mask", int'(bag_mask), 'h3F);

    // restart overrides pop and accept.
    rnd = 3'd7; piece_pop = 1'b1;
    cyc();
    chk("pre_restart_count", int'(count), 3);
    restart = 1'b1; rnd = 3'd6; piece_pop = 1'b1;
    cyc();
    restart = 1'b0; piece_pop = 1'b0;
    chk("restart_count", int'(count), 0);
    chk("restart_mask", int'(bag_mask), 0);
    chk("restart_valid", int'(piece_valid), 0);

    // Invalid stream: fallback issues 0,1,2,3 each after MAX_TRIES cycles.
    rnd = 3'd7;
    repeat (7) cyc();
    chk("inv_wait_count", int'(count), 0);
    cyc();
    chk("inv_first_count", int'(count), 1);
    chk("inv_first_id", int'(piece_id), 0);
    repeat (8) cyc();
    chk("inv_second_count", int'(count), 2);
    chk("inv_second_id", int'(preview_id), 1);
    repeat (16) cyc();
    chk("inv_full_count", int'(count), 4);
    chk("inv_full_mask", int'(bag_mask), 'h0F);

    // Continuous pop with an LFSR-driven stream.
    lfsr = 16'hACE1;
    piece_pop = 1'b1;
    for (int c = 0; c < 3000 && popped.size() < 70; c++) begin
      if (piece_valid) popped.push_back(int'(piece_id));
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rnd  = lfsr[2:0];
      cyc();
    end
    piece_pop = 1'b0;
    chk("lfsr_popped", popped.size(), 70);
    for (int w = 0; w + 7 <= popped.size(); w += 7) begin
      int seen;
      seen = 0;
      for (int k = 0; k < 7; k++) if (popped[w+k] <= 6) seen |= (1 << popped[w+k]);
      chk("bag_window", seen, 'h7F);
    end

    // Asynchronous reset in the middle of a draw.
    rnd = 3'd7;
    repeat (3) cyc();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(piece_valid), 0);
    chk("mid_rst_piece_id", int'(piece_id), 0);
    chk("mid_rst_preview_valid", int'(preview_valid), 0);
    chk("mid_rst_preview_id", int'(preview_id), 0);
    chk("mid_rst_mask", int'(bag_mask), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_init_count", int'(count), 0);
    rnd = 3'd2;
    cyc();
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_piece_id", int'(piece_id), 2);
    chk("post_rst_mask", int'(bag_mask), 'h04);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
